// File: rtl/exc_pkg.sv
// exc_pkg: ExcCodes, Status bit indices, source indices and FSM state type shared with CP0.
package exc_pkg;
  localparam logic [3:0] EXC_SYSCALL = 4'b1000;
  localparam logic [3:0] EXC_BREAK   = 4'b1001;
  localparam logic [3:0] EXC_TEQ     = 4'b1101;
  localparam logic [3:0] EXC_INT     = 4'b0000;
  localparam int STAT_IE     = 0;
  localparam int STAT_SYS_EN = 1;
  localparam int STAT_BRK_EN = 2;
  localparam int STAT_TEQ_EN = 3;
  localparam int STAT_IM_LO  = 8;
  localparam int STAT_IM_HI  = 11;
  localparam int SRC_SYS = 0;
  localparam int SRC_BRK = 1;
  localparam int SRC_TEQ = 2;
  localparam int SRC_INT = 3;
`ifdef EXC_REQ_EXT_IRQ_EN
  localparam int NSRC = 4;
`else
  localparam int NSRC = 3;
`endif
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_REQ  = 2'd1;
  localparam state_t S_HND  = 2'd2;
endpackage

// File: rtl/exc_prio_enc.sv
// exc_prio_enc: fixed-priority pick BREAK > SYSCALL > TEQ (> INT with EXC_REQ_EXT_IRQ_EN).
module exc_prio_enc
  import exc_pkg::*;
#(
  parameter int N = NSRC
) (
  input  logic [N-1:0] pend,
  output logic [N-1:0] win,
  output logic [3:0]   cause,
  output logic         any
);
  always_comb begin
    win = '0;
    cause = EXC_INT;
    if (pend[SRC_BRK]) begin
      win[SRC_BRK] = 1'b1;
      cause = EXC_BREAK;
    end else if (pend[SRC_SYS]) begin
      win[SRC_SYS] = 1'b1;
      cause = EXC_SYSCALL;
    end else if (pend[SRC_TEQ]) begin
      win[SRC_TEQ] = 1'b1;
      cause = EXC_TEQ;
`ifdef EXC_REQ_EXT_IRQ_EN
    end else if (pend[SRC_INT]) begin
      win[SRC_INT] = 1'b1;
      cause = EXC_INT;
`endif
    end
  end
  assign any = |pend;
endmodule

// File: rtl/exc_req_ctrl.sv
// exc_req_ctrl: pends SYSCALL/BREAK/TEQ (and INT with EXC_REQ_EXT_IRQ_EN), issues to CP0, tracks handler.
module exc_req_ctrl
  import exc_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        syscall_i,
  input  logic        break_i,
  input  logic        teq_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] status_i,
  input  logic        ack_i,
  input  logic        eret_i,
`ifdef EXC_REQ_EXT_IRQ_EN
  input  logic [3:0]  irq_i,
`endif
  output logic        req_o,
  output logic [3:0]  cause_o,
  output logic [31:0] epc_o,
  output logic        stall_o,
  output logic        busy_o,
  output logic        err_o,
  output logic [7:0]  drop_cnt_o
);
  state_t st;
  logic [2:0] pend, stb, en, new_p;
  logic [31:0] pcq [3];
  logic [NSRC-1:0] eff, win;
  logic [3:0] win_cause;
  logic [31:0] win_pc;
  logic [7:0] cnt;
  logic any, issue, drop, unused;
  assign stb = {teq_i, break_i, syscall_i};
  assign en = {status_i[STAT_TEQ_EN], status_i[STAT_BRK_EN], status_i[STAT_SYS_EN]} & {3{status_i[STAT_IE]}};
  assign new_p = stb & en & ~pend;
  assign drop = |(stb & ~en);
`ifdef EXC_REQ_EXT_IRQ_EN
  assign eff = {status_i[STAT_IE] & |(irq_i & status_i[STAT_IM_HI:STAT_IM_LO]), pend | new_p};
  assign unused = ^{status_i[31:12], status_i[7:4]};
`else
  assign eff = pend | new_p;
  assign unused = ^status_i[31:4];
`endif
  exc_prio_enc #(.N(NSRC)) u_enc (
    .pend (eff),
    .win  (win),
    .cause(win_cause),
    .any  (any)
  );
  assign issue = (st == S_IDLE) && any;
  // A source strobed this very cycle has no captured PC yet, so it takes pc_i directly.
  always_comb begin
    win_pc = '0;
    for (int i = 0; i < 3; i++) win_pc |= {32{win[i]}} & (pend[i] ? pcq[i] : pc_i);
`ifdef EXC_REQ_EXT_IRQ_EN
    win_pc |= {32{win[SRC_INT]}} & pc_i;
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= S_IDLE;
      pend <= '0;
      cause_o <= '0;
      epc_o <= '0;
      cnt <= '0;
      err_o <= 1'b0;
      drop_cnt_o <= '0;
      for (int i = 0; i < 3; i++) pcq[i] <= '0;
    end else begin
      err_o <= 1'b0;
      drop_cnt_o <= drop_cnt_o + 8'(drop && drop_cnt_o != 8'hff);
      pend <= (pend | new_p) & ~(issue ? win[2:0] : 3'b000);
      for (int i = 0; i < 3; i++) if (new_p[i]) pcq[i] <= pc_i;
      case (st)
        S_IDLE: if (any) begin
          st <= S_REQ;
          cause_o <= win_cause;
          epc_o <= win_pc;
          cnt <= '0;
        end
        S_REQ: if (ack_i) st <= S_HND;
          else if (cnt == 8'(ACK_TIMEOUT - 1)) begin
            st <= S_IDLE;
            err_o <= 1'b1;
          end else cnt <= cnt + 8'd1;
        S_HND: if (eret_i) st <= S_IDLE;
        default: st <= S_IDLE;
      endcase
    end
  assign req_o = st == S_REQ;
  assign stall_o = st == S_REQ;
  assign busy_o = st == S_HND;
endmodule

// File: doc/exc_req_ctrl.md
EXC_REQ_CTRL -- requirements
Module: exc_req_ctrl

Interface
REQ-001 Parameter ACK_TIMEOUT, default 15: max cycles in REQ before the request is abandoned (1..255).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 syscall_i  input  1  decode-stage SYSCALL strobe, one cycle.
REQ-005 break_i  input  1  decode-stage BREAK strobe, one cycle.
REQ-006 teq_i  input  1  TEQ strobe whose compare condition is already true, one cycle.
REQ-007 pc_i  input  32  PC of the instruction raising the strobe.
REQ-008 status_i  input  32  live CP0 Status; bit0 global enable, bits1/2/3 SYSCALL/BREAK/TEQ enables.
REQ-009 ack_i  input  1  CP0 accepted the exception this cycle.
REQ-010 eret_i  input  1  ERET retiring this cycle.
REQ-011 req_o  output  1  exception request to CP0.
REQ-012 cause_o  output  4  ExcCode: SYSCALL 4'b1000, BREAK 4'b1001, TEQ 4'b1101, INT 4'b0000.
REQ-013 epc_o  output  32  PC associated with cause_o.
REQ-014 stall_o  output  1  freeze pipeline while a request is in flight.
REQ-015 busy_o  output  1  handler active (between ack and ERET).
REQ-016 err_o  output  1  one-cycle pulse on ACK_TIMEOUT expiry.
REQ-017 drop_cnt_o  output  8  saturating count of strobes discarded because masked.

Function
REQ-018 FSM states IDLE, REQ, HANDLER; encoding free.
REQ-019 Source enabled iff status_i[0] and its per-source bit set; disabled strobes increment drop_cnt_o (saturate at 255), one increment per cycle max.
REQ-020 Enabled strobes set sticky pending bits pend[SYSCALL/BREAK/TEQ], each with a captured PC; a re-strobe of an already-pending source overwrites nothing and is ignored.
REQ-021 Priority when several pending: BREAK > SYSCALL > TEQ (> INT when compiled).
REQ-022 IDLE with any pending bit: next cycle enter REQ, latch winner's cause and PC into cause_o/epc_o, clear winner's pending bit, req_o=1.
REQ-023 Strobe arriving in IDLE with nothing pending reaches req_o exactly one cycle later (latency 1).
REQ-024 In REQ, req_o, cause_o, epc_o held constant until ack_i; stall_o = (state==REQ).
REQ-025 ack_i in REQ: next cycle HANDLER, req_o=0, busy_o=1; ack_i outside REQ ignored.
REQ-026 Timeout counter starts at 0 on REQ entry; if ACK_TIMEOUT cycles pass without ack_i: err_o pulses, return to IDLE, request discarded (not re-pended).
REQ-027 ack_i on the timeout cycle wins: treated as accepted, no err_o.
REQ-028 In HANDLER new enabled strobes only pend; eret_i returns to IDLE next cycle, busy_o=0.
REQ-029 eret_i in IDLE or REQ ignored; strobe coinciding with eret_i is pended and issued from IDLE the following cycle.
REQ-030 cause_o/epc_o retain last value outside REQ.

Reset
REQ-031 rst asserted: state IDLE, pend=0, req_o=0, stall_o=0, busy_o=0, err_o=0, cause_o=0, epc_o=0, drop_cnt_o=0, timeout counter 0, immediately and regardless of clk.
REQ-032 Reset mid-REQ or mid-HANDLER discards all pending and in-flight requests; no err_o.

Configuration
REQ-033 Macro EXC_REQ_EXT_IRQ_EN: defined adds input irq_i[3:0] (level), masked by status_i[0] and status_i[11:8]; any enabled line pends INT (cause 4'b0000, epc = pc_i), lowest priority, re-pended while level persists after ERET.
REQ-034 Undefined: no irq_i port, no INT pending bit, INT cause never produced.

Structure
REQ-035 Shared package exc_pkg holds ExcCode constants (SYSCALL, BREAK, TEQ, INT), Status bit indices and the FSM state typedef; CP0 imports the same constants.
REQ-036 One sub-module natural: exc_prio_enc (combinational fixed-priority encoder: pend vector -> winner one-hot + cause).

Verification
REQ-037 status=0x0F, syscall_i pulse, pc_i=0x00400100 -> cycle+1 req_o=1, cause_o=4'b1000, epc_o=0x00400100; ack after 3 cycles -> busy_o=1, req_o=0.
REQ-038 break_i and teq_i same cycle, status=0x0F -> BREAK issued first; after ack+eret, TEQ issued with its own captured PC.
REQ-039 status=0x01, syscall_i 300 pulses -> req_o never asserts, drop_cnt_o=255.
REQ-040 ACK_TIMEOUT=4, no ack -> err_o pulse 4 cycles after req_o rise, state IDLE, req_o=0.
REQ-041 rst asserted mid-REQ between clock edges -> req_o, stall_o low before next edge; all pending cleared.
REQ-042 With EXC_REQ_EXT_IRQ_EN, status=0x101, irq_i=4'b0001 held -> cause_o=4'b0000; after ack+eret with irq still high, reissued.
